// File: rtl/aes_arb_pkg.sv
// aes_arb_pkg: shared types and widths for the AES job arbiter.
package aes_arb_pkg;

    localparam int unsigned AES_BLOCK_W = 128;

    typedef enum logic [1:0] {
        IDLE,
        RUN,
        DRAIN,
        RESP
    } aes_arb_state_t;

    // Index of a requester (0 or 1).
    typedef logic req_idx_t;

endpackage : aes_arb_pkg

// File: rtl/aes_job_arbiter_rr_arb2.sv
// rr_arb2: two-input round-robin arbiter with a one-hot grant.
// On a tie the favoured requester wins. The pointer then moves to the loser.
module rr_arb2
    import aes_arb_pkg::*;
(
    input  logic       i_clk,
    input  logic       i_rst_n,
    input  logic [1:0] i_req,
    input  logic       i_advance,
    output logic [1:0] o_grant
);

    req_idx_t r_ptr;

    // Grant the favoured requester on a tie, otherwise whoever is asking.
    always_comb begin
        o_grant = i_req;
        if (i_req == 2'b11) begin
            o_grant = r_ptr ? 2'b10 : 2'b01;
        end
    end

    // After each accept, favour the requester that did not just win.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_ptr <= 1'b0;
        end else if (i_advance) begin
            r_ptr <= ~o_grant[1];
        end
    end

endmodule : rr_arb2

// File: rtl/aes_job_arbiter.sv
// aes_job_arbiter: shares one AES decryptor core between two requesters.
// It grants the core round-robin and drives the level START/DONE handshake.
// The plaintext is returned with a one-cycle pulse to the job owner.
// Optional: define AES_ARB_WATCHDOG_EN to abort jobs whose DONE never arrives.
module aes_job_arbiter
    import aes_arb_pkg::*;
#(
    parameter int unsigned TIMEOUT_CYCLES = 1024
)
(
    input  logic                   CLK,
    input  logic                   RESET_N,
    input  logic                   REQ0_VALID,
    input  logic                   REQ1_VALID,
    output logic                   REQ0_READY,
    output logic                   REQ1_READY,
    input  logic [AES_BLOCK_W-1:0] REQ0_KEY,
    input  logic [AES_BLOCK_W-1:0] REQ1_KEY,
    input  logic [AES_BLOCK_W-1:0] REQ0_MSG,
    input  logic [AES_BLOCK_W-1:0] REQ1_MSG,
    output logic                   RSP0_VALID,
    output logic                   RSP1_VALID,
    output logic [AES_BLOCK_W-1:0] RSP_DATA,
    output logic                   RSP_ERR,
    output logic [AES_BLOCK_W-1:0] AES_KEY,
    output logic [AES_BLOCK_W-1:0] AES_MSG_ENC,
    output logic                   AES_START,
    input  logic                   AES_DONE,
    input  logic [AES_BLOCK_W-1:0] AES_MSG_DEC,
    output logic                   BUSY,
    output logic                   OWNER
);

    if (TIMEOUT_CYCLES < 1) begin : g_bad_timeout
        $error("TIMEOUT_CYCLES must be at least 1");
    end

    aes_arb_state_t         r_state;
    aes_arb_state_t         w_next;
    logic [1:0]             w_req;
    logic [1:0]             w_grant;
    logic                   w_accept;
    logic                   w_done_hit;
    logic                   w_timeout;
    logic [AES_BLOCK_W-1:0] r_key;
    logic [AES_BLOCK_W-1:0] r_msg;
    logic [AES_BLOCK_W-1:0] r_rsp_data;
    req_idx_t               r_owner;

    // READY is gated by RESET_N so every output reads 0 while reset is held.
    assign w_req      = (r_state == IDLE && RESET_N) ? {REQ1_VALID, REQ0_VALID} : 2'b00;
    assign w_accept   = |w_grant;
    assign w_done_hit = (r_state == RUN) && AES_DONE;

    rr_arb2 u_rr_arb2 (
        .i_clk     (CLK),
        .i_rst_n   (RESET_N),
        .i_req     (w_req),
        .i_advance (w_accept),
        .o_grant   (w_grant)
    );

    // FSM state register.
    always_ff @(posedge CLK or negedge RESET_N) begin
        if (!RESET_N) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_next;
        end
    end

    // Next-state logic and state-decoded outputs.
    always_comb begin
        w_next     = r_state;
        AES_START  = 1'b0;
        BUSY       = (r_state != IDLE);
        REQ0_READY = w_grant[0];
        REQ1_READY = w_grant[1];
        RSP0_VALID = 1'b0;
        RSP1_VALID = 1'b0;
        case (r_state)
            IDLE: begin
                if (w_accept) begin
                    w_next = RUN;
                end
            end
            RUN: begin
                AES_START = 1'b1;
                if (w_done_hit || w_timeout) begin
                    w_next = DRAIN;
                end
            end
            DRAIN: begin
                if (!AES_DONE) begin
                    w_next = RESP;
                end
            end
            RESP: begin
                RSP0_VALID = (r_owner == 1'b0);
                RSP1_VALID = (r_owner == 1'b1);
                w_next     = IDLE;
            end
            default: begin
                w_next = IDLE;
            end
        endcase
    end

    // Job latch on accept and result capture when the core finishes or is aborted.
    always_ff @(posedge CLK or negedge RESET_N) begin
        if (!RESET_N) begin
            r_key      <= '0;
            r_msg      <= '0;
            r_owner    <= 1'b0;
            r_rsp_data <= '0;
        end else begin
            if (w_accept) begin
                r_key   <= w_grant[1] ? REQ1_KEY : REQ0_KEY;
                r_msg   <= w_grant[1] ? REQ1_MSG : REQ0_MSG;
                r_owner <= w_grant[1];
            end
            if (w_done_hit) begin
                r_rsp_data <= AES_MSG_DEC;
            end else if (w_timeout) begin
                r_rsp_data <= '0;
            end
        end
    end

`ifdef AES_ARB_WATCHDOG_EN
    logic [31:0] r_wd_cnt;
    logic        r_rsp_err;

    // RUN-cycle counter and abort flag; the counter restarts at every accept.
    always_ff @(posedge CLK or negedge RESET_N) begin
        if (!RESET_N) begin
            r_wd_cnt  <= '0;
            r_rsp_err <= 1'b0;
        end else begin
            if (w_accept) begin
                r_wd_cnt <= '0;
            end else if (r_state == RUN) begin
                r_wd_cnt <= r_wd_cnt + 32'd1;
            end
            if (w_done_hit) begin
                r_rsp_err <= 1'b0;
            end else if (w_timeout) begin
                r_rsp_err <= 1'b1;
            end
        end
    end

    assign w_timeout = (r_state == RUN) && !AES_DONE && (r_wd_cnt == TIMEOUT_CYCLES - 1);
    assign RSP_ERR   = r_rsp_err;
`else
    assign w_timeout = 1'b0;
    assign RSP_ERR   = 1'b0;
`endif

    assign AES_KEY     = r_key;
    assign AES_MSG_ENC = r_msg;
    assign RSP_DATA    = r_rsp_data;
    assign OWNER       = r_owner;

endmodule : aes_job_arbiter
